// File: rtl/boxhead_soc_key_pio_if.sv
// Avalon-MM slave bus bundle for the key/switch input PIO.
// The master drives the address and write signals; the slave returns registered read data.
interface boxhead_soc_key_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/boxhead_soc_key_pio.sv
// Debounced push-button / switch input PIO with edge capture and a maskable level interrupt.
// Register map: 0 = debounced data, 1 = reserved (reads 0), 2 = irq mask, 3 = edge capture (W1C).
// Optional feature macro: BOXHEAD_KEY_PIO_DEBOUNCE_EN builds the per-bit debounce counters;
// without it the synchronised input is taken as the stable value on every clock.
module boxhead_soc_key_pio #(
  parameter int              WIDTH           = 4,
  parameter int              DEBOUNCE_CYCLES = 50000,
  parameter int              EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] INPUT_RESET    = {WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  reset_n,
  boxhead_soc_key_pio_if.slave  bus,
  input  logic [WIDTH-1:0]      in_port,
  output logic                  irq
);

  logic [WIDTH-1:0] s1_reg;
  logic [WIDTH-1:0] s2_reg;
  logic [WIDTH-1:0] stable_vec;
  logic [WIDTH-1:0] prev_reg;
  logic [WIDTH-1:0] edge_vec;
  logic [WIDTH-1:0] edge_capture_reg;
  logic [WIDTH-1:0] irq_mask_reg;
  logic [WIDTH-1:0] clr_vec;
  logic             wr_en;

  assign wr_en   = bus.chipselect & ~bus.write_n;
  assign clr_vec = (wr_en && (bus.address == 2'd3)) ? bus.writedata[WIDTH-1:0] : '0;

  // Upper write-data bits carry no meaning for narrow instances.
  generate
    if (WIDTH < 32) begin : g_wd_pad
      logic unused_writedata_hi;
      assign unused_writedata_hi = ^bus.writedata[31:WIDTH];
    end
  endgenerate

  // Two-flop synchroniser for the asynchronous pins; idles at the inputs' rest level.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_reg <= INPUT_RESET;
      s2_reg <= INPUT_RESET;
    end else begin
      s1_reg <= in_port;
      s2_reg <= s2_next_src(s1_reg);
    end
  end

  function automatic logic [WIDTH-1:0] s2_next_src(input logic [WIDTH-1:0] v);
    return v;
  endfunction

`ifdef BOXHEAD_KEY_PIO_DEBOUNCE_EN
  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_debounce
      logic [CNT_W-1:0] cnt_reg;
      logic             stable_bit_reg;

      // Accept a new level only after it has differed from the stable one for DEBOUNCE_CYCLES clocks.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          cnt_reg        <= '0;
          stable_bit_reg <= INPUT_RESET[gi];
        end else if (s2_reg[gi] == stable_bit_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
          cnt_reg        <= '0;
          stable_bit_reg <= s2_reg[gi];
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end

      assign stable_vec[gi] = stable_bit_reg;
    end
  endgenerate
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

  // Without debouncing the synchronised level is trusted directly.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stable_vec <= INPUT_RESET;
    end else begin
      stable_vec <= s2_reg;
    end
  end
`endif

  // Delayed copy of the stable level; equal to it after reset so no edge is seen.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_reg <= INPUT_RESET;
    end else begin
      prev_reg <= stable_vec;
    end
  end

  generate
    if (EDGE_TYPE == 0) begin : g_edge_rise
      assign edge_vec = stable_vec & ~prev_reg;
    end else if (EDGE_TYPE == 1) begin : g_edge_fall
      assign edge_vec = ~stable_vec & prev_reg;
    end else begin : g_edge_any
      assign edge_vec = stable_vec ^ prev_reg;
    end
  endgenerate

  // Sticky edge capture; a fresh edge beats a simultaneous write-one-to-clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      edge_capture_reg <= '0;
    end else begin
      edge_capture_reg <= edge_vec | (edge_capture_reg & ~clr_vec);
    end
  end

  // Interrupt mask loaded by software.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_mask_reg <= '0;
    end else if (wr_en && (bus.address == 2'd2)) begin
      irq_mask_reg <= bus.writedata[WIDTH-1:0];
    end
  end

  // Read data is registered every clock from the current address, chipselect not required.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.readdata <= '0;
    end else begin
      case (bus.address)
        2'd0:    bus.readdata <= 32'(stable_vec);
        2'd2:    bus.readdata <= 32'(irq_mask_reg);
        2'd3:    bus.readdata <= 32'(edge_capture_reg);
        default: bus.readdata <= '0;
      endcase
    end
  end

  assign irq = |(edge_capture_reg & irq_mask_reg);

endmodule

// File: tb/tb_boxhead_soc_key_pio.sv
// Bench for boxhead_soc_key_pio: three instances (rising, falling, any edge) share one stimulus.
// A window-based behavioural model predicts readdata/irq and is compared every negedge.
module tb_boxhead_soc_key_pio;

  localparam int DC = 4;
`ifdef BOXHEAD_KEY_PIO_DEBOUNCE_EN
  localparam int RD_LAT  = DC + 2;
  localparam int CAP_LAT = DC + 2;
  localparam logic [31:0] GL3_CAP = 32'h0;
  localparam logic [31:0] GL1_CAP = 32'h0;
`else
  localparam int RD_LAT  = 3;
  localparam int CAP_LAT = 3;
  localparam logic [31:0] GL3_CAP = 32'h1;
  localparam logic [31:0] GL1_CAP = 32'h4;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  in_port;
  logic [1:0]  address;
  logic        cs;
  logic        write_n;
  logic [31:0] writedata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  boxhead_soc_key_pio_if bus0 ();
  boxhead_soc_key_pio_if bus1 ();
  boxhead_soc_key_pio_if bus2 ();

  assign bus0.address = address;  assign bus0.chipselect = cs;
  assign bus0.write_n = write_n;  assign bus0.writedata  = writedata;
  assign bus1.address = address;  assign bus1.chipselect = cs;
  assign bus1.write_n = write_n;  assign bus1.writedata  = writedata;
  assign bus2.address = address;  assign bus2.chipselect = cs;
  assign bus2.write_n = write_n;  assign bus2.writedata  = writedata;

  logic irq0, irq1, irq2;
  logic [31:0] rd0, rd1, rd2;
  assign rd0 = bus0.readdata;
  assign rd1 = bus1.readdata;
  assign rd2 = bus2.readdata;

  boxhead_soc_key_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(0), .INPUT_RESET(4'hF)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0.slave), .in_port(in_port), .irq(irq0));
  boxhead_soc_key_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(1), .INPUT_RESET(4'hF)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1.slave), .in_port(in_port), .irq(irq1));
  boxhead_soc_key_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(2), .INPUT_RESET(4'hF)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2.slave), .in_port(in_port), .irq(irq2));

  // ---------------- behavioural model ----------------
  logic [3:0]  m_s1, m_s2, m_stable, m_prev, m_mask;
  logic [3:0]  m_win [DC];
  logic [3:0]  m_cap [3];
  logic [31:0] m_rd  [3];
  logic        m_valid = 1'b0;

  always @(posedge clk) begin
    logic [3:0] e;
    logic [3:0] clr;
    logic [3:0] n_stable;
    logic       all_diff;
    if (!reset_n) begin
      m_s1 = 4'hF; m_s2 = 4'hF; m_stable = 4'hF; m_prev = 4'hF; m_mask = 4'h0;
      for (int j = 0; j < DC; j++) m_win[j] = 4'hF;
      for (int k = 0; k < 3; k++) begin m_cap[k] = 4'h0; m_rd[k] = 32'h0; end
    end else begin
      clr = (cs && !write_n && address == 2'd3) ? writedata[3:0] : 4'h0;
      for (int k = 0; k < 3; k++) begin
        case (address)
          2'd0: m_rd[k] = {28'h0, m_stable};
          2'd2: m_rd[k] = {28'h0, m_mask};
          2'd3: m_rd[k] = {28'h0, m_cap[k]};
          default: m_rd[k] = 32'h0;
        endcase
        if (k == 0)      e = m_stable & ~m_prev;
        else if (k == 1) e = ~m_stable & m_prev;
        else             e = m_stable ^ m_prev;
        m_cap[k] = e | (m_cap[k] & ~clr);
      end
      if (cs && !write_n && address == 2'd2) m_mask = writedata[3:0];
      m_prev = m_stable;
`ifdef BOXHEAD_KEY_PIO_DEBOUNCE_EN
      // Stable flips once the last DC synchronised samples all disagree with it.
      for (int j = DC - 1; j > 0; j--) m_win[j] = m_win[j-1];
      m_win[0] = m_s2;
      n_stable = m_stable;
      for (int b = 0; b < 4; b++) begin
        all_diff = 1'b1;
        for (int j = 0; j < DC; j++) if (m_win[j][b] == m_stable[b]) all_diff = 1'b0;
        if (all_diff) n_stable[b] = m_s2[b];
      end
`else
      n_stable = m_s2;
`endif
      m_stable = n_stable;
      m_s2 = m_s1;
      m_s1 = in_port;
    end
    m_valid = 1'b1;
  end

  // ---------------- every-cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      for (int k = 0; k < 3; k++) begin
        logic [31:0] act_rd;
        logic        act_irq;
        act_rd  = (k == 0) ? rd0 : (k == 1) ? rd1 : rd2;
        act_irq = (k == 0) ? irq0 : (k == 1) ? irq1 : irq2;
        checks++;
        if (act_rd !== m_rd[k]) begin
          errors++;
          $display("FAIL model_readdata dut%0d t=%0t got %h expected %h", k, $time, act_rd, m_rd[k]);
        end
        checks++;
        if (act_irq !== |(m_cap[k] & m_mask)) begin
          errors++;
          $display("FAIL model_irq dut%0d t=%0t got %b expected %b", k, $time, act_irq, |(m_cap[k] & m_mask));
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic clocks(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; cs = 1'b1; write_n = 1'b0; writedata = d;
    clocks(1);
    cs = 1'b0; write_n = 1'b1; writedata = 32'h0;
    $display("write addr=%0d data=%h", a, d);
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end else begin
      $display("check %s = %h", name, act);
    end
  endtask

  initial begin
    reset_n = 1'b0; in_port = 4'h0; address = 2'd0; cs = 1'b0; write_n = 1'b1; writedata = 32'h0;
    clocks(3);
    lit("reset_readdata", rd1, 32'h0);
    lit("reset_irq", {31'h0, irq1}, 32'h0);
    reset_n = 1'b1; in_port = 4'hF;
    clocks(3);
    lit("idle_data", rd1, 32'hF);
    address = 2'd3; clocks(1);
    lit("idle_capture", rd1, 32'h0);

    // 3-clock glitch on bit 0
    in_port = 4'hE; clocks(3); in_port = 4'hF; clocks(10);
    lit("glitch3_capture", rd1, GL3_CAP);
    wr(2'd3, 32'hF);

    // bit 0 pressed permanently: read-data latency pinned on both sides
    address = 2'd0; clocks(1);
    in_port = 4'hE; clocks(RD_LAT);
    lit("press0_before", rd1, 32'hF);
    clocks(1);
    lit("press0_data", rd1, 32'hE);
    address = 2'd3; clocks(1);
    lit("press0_capture", rd1, 32'h1);
    lit("press0_irq_masked", {31'h0, irq1}, 32'h0);
    wr(2'd2, 32'h1);
    lit("mask_irq_rise", {31'h0, irq1}, 32'h1);
    wr(2'd3, 32'h1);
    lit("clear_irq_fall", {31'h0, irq1}, 32'h0);
    address = 2'd3; clocks(1);
    lit("clear_capture", rd1, 32'h0);

    // bit 1: capture, clear, release, then re-press landing on a clear edge
    in_port = 4'hC; clocks(10); wr(2'd3, 32'hF);
    in_port = 4'hE; clocks(10); wr(2'd3, 32'hF);
    in_port = 4'hC; clocks(CAP_LAT);
    wr(2'd3, 32'h2);
    address = 2'd3; clocks(1);
    lit("set_beats_clear", rd1, 32'h2);

    // upper writedata bits ignored, address 1 inert
    wr(2'd2, 32'hFFFF_FFF0);
    address = 2'd2; clocks(1);
    lit("mask_upper_ignored", rd1, 32'h0);
    wr(2'd1, 32'hFFFF_FFFF);
    address = 2'd1; clocks(1);
    lit("addr1_zero", rd1, 32'h0);
    wr(2'd2, 32'hF);

    // bit 2 release: only rising/any instances capture
    wr(2'd3, 32'hF);
    in_port = 4'h8; clocks(10); wr(2'd3, 32'hF);
    in_port = 4'hC; clocks(10);
    address = 2'd3; clocks(1);
    lit("release_fall_inst", rd1, 32'h0);
    lit("release_any_inst", rd2, 32'h4);
    lit("release_rise_inst", rd0, 32'h4);
    lit("release_any_irq", {31'h0, irq2}, 32'h1);

    // bit 3 press latency
    wr(2'd3, 32'hF);
    in_port = 4'hF; clocks(10); wr(2'd3, 32'hF);
    address = 2'd0; clocks(1);
    lit("bit3_idle", rd1, 32'hF);
    in_port = 4'h7; clocks(RD_LAT);
    lit("bit3_before", rd1, 32'hF);
    clocks(1);
    lit("bit3_data", rd1, 32'h7);

    // 1-clock glitch on bit 2
    clocks(4); wr(2'd3, 32'hF);
    in_port = 4'h3; clocks(1); in_port = 4'h7; clocks(10);
    address = 2'd3; clocks(1);
    lit("glitch1_capture", rd1, GL1_CAP);
    wr(2'd3, 32'hF);

    // capture then reset mid-debounce
    in_port = 4'h6; clocks(10);
    address = 2'd3; clocks(1);
    lit("pre_reset_capture", rd1, 32'h1);
    lit("pre_reset_irq", {31'h0, irq1}, 32'h1);
    in_port = 4'h4; clocks(2);
    reset_n = 1'b0; clocks(1);
    reset_n = 1'b1; clocks(1);
    lit("post_reset_capture", rd1, 32'h0);
    lit("post_reset_irq", {31'h0, irq1}, 32'h0);
    address = 2'd2; clocks(1);
    lit("post_reset_mask", rd1, 32'h0);
    clocks(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
